usb_gpx_conditioner: RTL and testbench
======================================

# usb_gpx_conditioner

Conditions the raw GPX output of the USB host controller before it reaches the system. The block synchronises the asynchronous GPX pin, rejects glitches shorter than a programmable number of clocks, and detects edges on the filtered level. It exposes a small Avalon-MM register slave with edge-capture, interrupt-mask and event-count registers plus an `irq` line. The filtered level is also driven out on `gpx_filt`, which feeds the 1-bit GPX PIO input port directly downstream.

## Interface
- `FILTER_LEN`, default 4: number of consecutive synchronised cycles at a new level required before `gpx_filt` accepts it; legal range 1..255.
- `EDGE_MODE`, default 0: edge that sets capture. 0 = rising, 1 = falling, 2 = both.
- `CNT_W`, default 16: event counter width, 1..32.
- `IDLE_LEVEL`, default 0: reset value of the synchroniser flops, the filter output and the edge-detect delay flop.

- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low; clock is `clk`.
- `gpx_async` in 1: raw GPX pin, asynchronous to `clk`.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: interrupt, `edgecapture & irqmask`.
- `gpx_filt` out 1: filtered GPX level, drives the downstream PIO `in_port`.

## Operation
- **Synchroniser.** Two flops, `s1` then `s2`.
- **Filter.** Counter `fcnt` counts consecutive cycles in which `s2 != gpx_filt`.
  - If `s2 == gpx_filt`: `fcnt` clears to 0.
  - Else if `fcnt == FILTER_LEN-1`: `gpx_filt` takes `s2` and `fcnt` clears to 0.
  - Else: `fcnt` increments.
- **Edge detect.** `filt_d` holds `gpx_filt` delayed one cycle.
  - Rising edge: `gpx_filt & ~filt_d`. Falling edge: `~gpx_filt & filt_d`.
  - An edge of the type selected by `EDGE_MODE` is an event.
  - An event sets `edgecapture` and increments `evcnt`, which wraps modulo 2^CNT_W.
- **Registers.** Read data is zero-extended to 32 bits.
  - Address 0, DATA: R = `gpx_filt`; writes are ignored.
  - Address 1, IRQMASK: R/W, bit 0 only.
  - Address 2, EDGECAP: R = `edgecapture`; writing 1 to bit 0 clears it; writing 0 has no effect.
  - Address 3, EVCNT: R = `evcnt`; a write of any value clears it.
- **Simultaneous events.**
  - Event and EDGECAP clear in the same cycle: set wins, `edgecapture` stays 1.
  - Event and EVCNT write in the same cycle: `evcnt` becomes 1.
- **`irq`.** Combinational AND of the registered `edgecapture` and `irqmask`; no extra latency.
- **Reset values.**
  - `readdata`, `irqmask`, `edgecapture`, `evcnt` and `fcnt` reset to 0.
  - `s1`, `s2`, `gpx_filt` and `filt_d` reset to `IDLE_LEVEL`.
  - Consequently no edge is reported after reset while the pin sits at `IDLE_LEVEL`.
- **Reset mid-filter.** Asserting reset during a filter count discards the count; filtering restarts from `IDLE_LEVEL`.

## Timing
- **Filter latency.** A `gpx_async` change captured by rising edge k appears on `gpx_filt` at edge k+FILTER_LEN+1, i.e. the (FILTER_LEN+2)th edge. With `FILTER_LEN`=4 that is 6 clocks.
- **Glitch rejection.** A pulse held in `s2` for fewer than `FILTER_LEN` cycles never reaches `gpx_filt`.
- **Edge to `irq`.** `edgecapture` and `irq` assert 2 edges after the `gpx_filt` change (`filt_d` compare, then register). Both assert on the same edge.
- **Reads.** `readdata` is updated on every clock from the `address` mux regardless of `chipselect`; read latency is 1 cycle.
- **Writes.** Take effect on the clock edge where `chipselect & ~write_n` is sampled.
- **`irqmask` change.** Reflected on `irq` in the same cycle the register updates.

## Structure
- **Shared package `usb_gpx_pkg`:**
  - register address constants `GPX_REG_DATA`=0, `GPX_REG_IRQMASK`=1, `GPX_REG_EDGECAP`=2, `GPX_REG_EVCNT`=3;
  - `EDGE_MODE` encodings `GPX_EDGE_RISE`, `GPX_EDGE_FALL`, `GPX_EDGE_BOTH`.
- **Sub-module `usb_gpx_filter`:** holds the synchroniser and glitch filter (params `FILTER_LEN`, `IDLE_LEVEL`; output `gpx_filt`).
- **Top level:** holds edge detect, registers and `irq`.

## Test plan
- **Clean rise.** Defaults; drive `gpx_async` 0→1 and hold. Require `gpx_filt`=1 exactly 6 clocks later, `edgecapture`=1 and `evcnt`=1 two clocks after that, and DATA read = 0x00000001.
- **Glitch.** Drive a 3-clock high pulse with `FILTER_LEN`=4. Require `gpx_filt`, `edgecapture` and `evcnt` to remain 0.
- **Interrupt path.** Write IRQMASK=1, then produce a rising edge; require `irq`=1. Write 1 to EDGECAP; require `irq`=0 the cycle after the write and EDGECAP read = 0. Writing 0 to EDGECAP must leave a set bit set.
- **Simultaneous.** Align an EDGECAP clear and an EVCNT write with an event cycle. Require `edgecapture`=1 and `evcnt`=1.
- **Modes and wrap.** `EDGE_MODE`=2, `CNT_W`=4; apply 17 transitions. Require `evcnt`=1 after wrap. `EDGE_MODE`=1 must count only high→low transitions.
- **Reset.** Assert `reset_n` mid-filter count with `IDLE_LEVEL`=1 and the pin high. Require all outputs at reset values, `gpx_filt`=1 and no edge or `irq` after release.

Source files
------------

// File: rtl/usb_gpx_pkg.sv
// Shared constants for the USB GPX conditioner: register map and edge-mode encodings.
package usb_gpx_pkg;

  localparam logic [1:0] GPX_REG_DATA    = 2'd0;
  localparam logic [1:0] GPX_REG_IRQMASK = 2'd1;
  localparam logic [1:0] GPX_REG_EDGECAP = 2'd2;
  localparam logic [1:0] GPX_REG_EVCNT   = 2'd3;

  localparam int GPX_EDGE_RISE = 0;
  localparam int GPX_EDGE_FALL = 1;
  localparam int GPX_EDGE_BOTH = 2;

endpackage

// File: rtl/usb_gpx_filter.sv
// Two-flop synchroniser followed by a consecutive-cycle glitch filter on the GPX pin.
module usb_gpx_filter #(
  parameter int   FILTER_LEN = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_gpx_async,
  output logic o_gpx_filt
);

  localparam logic [7:0] FCNT_LAST = 8'(FILTER_LEN - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_filt;
  logic [7:0] r_fcnt;
  logic [7:0] w_fcnt_nxt;
  logic       w_filt_nxt;

  // Filter next state: a new level must persist FILTER_LEN sampled cycles
  always_comb begin
    w_fcnt_nxt = r_fcnt;
    w_filt_nxt = r_filt;
    if (r_s2 == r_filt) begin
      w_fcnt_nxt = 8'd0;
    end else if (r_fcnt == FCNT_LAST) begin
      w_filt_nxt = r_s2;
      w_fcnt_nxt = 8'd0;
    end else begin
      w_fcnt_nxt = r_fcnt + 8'd1;
    end
  end

  // Synchroniser and filter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= IDLE_LEVEL;
      r_s2   <= IDLE_LEVEL;
      r_filt <= IDLE_LEVEL;
      r_fcnt <= 8'd0;
    end else begin
      r_s1   <= i_gpx_async;
      r_s2   <= r_s1;
      r_filt <= w_filt_nxt;
      r_fcnt <= w_fcnt_nxt;
    end
  end

  assign o_gpx_filt = r_filt;

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX conditioner top: filtered level, edge capture/count registers on an Avalon-MM slave, irq.
module usb_gpx_conditioner
  import usb_gpx_pkg::*;
#(
  parameter int   FILTER_LEN = 4,
  parameter int   EDGE_MODE  = 0,
  parameter int   CNT_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_gpx_async,
  input  logic [1:0]  i_address,
  input  logic        i_chipselect,
  input  logic        i_write_n,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  output logic        o_irq,
  output logic        o_gpx_filt
);

  logic             w_filt;
  logic             r_filt_d;
  logic             r_event;
  logic             r_irqmask;
  logic             r_edgecap;
  logic [CNT_W-1:0] r_evcnt;
  logic [31:0]      r_readdata;

  logic             w_edge;
  logic             w_wr;
  logic             w_irqmask_nxt;
  logic             w_edgecap_nxt;
  logic [CNT_W-1:0] w_evcnt_nxt;
  logic [31:0]      w_rdmux;
  logic             w_unused;

  usb_gpx_filter #(
    .FILTER_LEN (FILTER_LEN),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_filter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_gpx_async (i_gpx_async),
    .o_gpx_filt  (w_filt)
  );

  assign w_wr     = i_chipselect & ~i_write_n;
  assign w_unused = &{1'b0, i_writedata[31:1]};

  // Edge selection on the filtered level
  always_comb begin
    w_edge = 1'b0;
    case (EDGE_MODE)
      GPX_EDGE_RISE: w_edge = w_filt & ~r_filt_d;
      GPX_EDGE_FALL: w_edge = ~w_filt & r_filt_d;
      GPX_EDGE_BOTH: w_edge = w_filt ^ r_filt_d;
      default:       w_edge = w_filt & ~r_filt_d;
    endcase
  end

  // Register next state; a same-cycle event always beats a software clear
  always_comb begin
    w_irqmask_nxt = r_irqmask;
    w_edgecap_nxt = r_edgecap;
    w_evcnt_nxt   = r_evcnt;
    if (w_wr && (i_address == GPX_REG_IRQMASK)) begin
      w_irqmask_nxt = i_writedata[0];
    end else begin
      w_irqmask_nxt = r_irqmask;
    end
    if (r_event) begin
      w_edgecap_nxt = 1'b1;
    end else if (w_wr && (i_address == GPX_REG_EDGECAP) && i_writedata[0]) begin
      w_edgecap_nxt = 1'b0;
    end else begin
      w_edgecap_nxt = r_edgecap;
    end
    if (w_wr && (i_address == GPX_REG_EVCNT)) begin
      w_evcnt_nxt = r_event ? CNT_W'(1) : CNT_W'(0);
    end else if (r_event) begin
      w_evcnt_nxt = r_evcnt + CNT_W'(1);
    end else begin
      w_evcnt_nxt = r_evcnt;
    end
  end

  // Read mux, sampled every clock independent of chipselect
  always_comb begin
    w_rdmux = 32'd0;
    case (i_address)
      GPX_REG_DATA:    w_rdmux = {31'd0, w_filt};
      GPX_REG_IRQMASK: w_rdmux = {31'd0, r_irqmask};
      GPX_REG_EDGECAP: w_rdmux = {31'd0, r_edgecap};
      GPX_REG_EVCNT:   w_rdmux = 32'(r_evcnt);
      default:         w_rdmux = 32'd0;
    endcase
  end

  // Edge pipeline and slave registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_d   <= IDLE_LEVEL;
      r_event    <= 1'b0;
      r_irqmask  <= 1'b0;
      r_edgecap  <= 1'b0;
      r_evcnt    <= CNT_W'(0);
      r_readdata <= 32'd0;
    end else begin
      r_filt_d   <= w_filt;
      r_event    <= w_edge;
      r_irqmask  <= w_irqmask_nxt;
      r_edgecap  <= w_edgecap_nxt;
      r_evcnt    <= w_evcnt_nxt;
      r_readdata <= w_rdmux;
    end
  end

  assign o_readdata = r_readdata;
  assign o_irq      = r_edgecap & r_irqmask;
  assign o_gpx_filt = w_filt;

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Self-checking bench for usb_gpx_conditioner: four instances cover rise/both/fall modes and IDLE_LEVEL=1.
module tb_usb_gpx_conditioner;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_ECAP = 2'd2;
  localparam logic [1:0] A_EVC  = 2'd3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  logic        clk;
  logic        reset_n;
  logic        gpx  [4];
  logic [1:0]  addr [4];
  logic        cs   [4];
  logic        wn   [4];
  logic [31:0] wd   [4];
  logic [31:0] rd   [4];
  logic        irq  [4];
  logic        filt [4];

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  usb_gpx_conditioner #(.FILTER_LEN(4), .EDGE_MODE(0), .CNT_W(16), .IDLE_LEVEL(1'b0)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .i_gpx_async(gpx[0]), .i_address(addr[0]), .i_chipselect(cs[0]),
    .i_write_n(wn[0]), .i_writedata(wd[0]), .o_readdata(rd[0]), .o_irq(irq[0]), .o_gpx_filt(filt[0]));
  usb_gpx_conditioner #(.FILTER_LEN(4), .EDGE_MODE(2), .CNT_W(4), .IDLE_LEVEL(1'b0)) u_dut_both (
    .clk(clk), .reset_n(reset_n), .i_gpx_async(gpx[1]), .i_address(addr[1]), .i_chipselect(cs[1]),
    .i_write_n(wn[1]), .i_writedata(wd[1]), .o_readdata(rd[1]), .o_irq(irq[1]), .o_gpx_filt(filt[1]));
  usb_gpx_conditioner #(.FILTER_LEN(4), .EDGE_MODE(1), .CNT_W(16), .IDLE_LEVEL(1'b0)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .i_gpx_async(gpx[2]), .i_address(addr[2]), .i_chipselect(cs[2]),
    .i_write_n(wn[2]), .i_writedata(wd[2]), .o_readdata(rd[2]), .o_irq(irq[2]), .o_gpx_filt(filt[2]));
  usb_gpx_conditioner #(.FILTER_LEN(4), .EDGE_MODE(0), .CNT_W(16), .IDLE_LEVEL(1'b1)) u_dut_idle1 (
    .clk(clk), .reset_n(reset_n), .i_gpx_async(gpx[3]), .i_address(addr[3]), .i_chipselect(cs[3]),
    .i_write_n(wn[3]), .i_writedata(wd[3]), .o_readdata(rd[3]), .o_irq(irq[3]), .o_gpx_filt(filt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
    addr[i] = a;
    wd[i]   = d;
    cs[i]   = 1'b1;
    wn[i]   = 1'b0;
    tick();
    cs[i]   = 1'b0;
    wn[i]   = 1'b1;
  endtask

  // Push the expectation at issue, pop it when readdata comes back one clock later
  task automatic rd_exp(input int i, input logic [1:0] a, input logic [31:0] e, input string tag);
    sb_t s;
    sb_q.push_back('{tag: tag, val: e});
    addr[i] = a;
    tick();
    s = sb_q.pop_front();
    chk(s.tag, rd[i], s.val);
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gpx[i] = (i == 3) ? 1'b1 : 1'b0;
      addr[i] = A_DATA;
      cs[i] = 1'b0;
      wn[i] = 1'b1;
      wd[i] = 32'd0;
    end
    ticks(3);
    reset_n = 1'b1;

    // Reset state on every instance
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rd%0d", i), rd[i], 32'd0);
      chk($sformatf("rst_irq%0d", i), {31'd0, irq[i]}, 32'd0);
      chk($sformatf("rst_filt%0d", i), {31'd0, filt[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    rd_exp(0, A_EVC, 32'd0, "rst_evcnt");
    rd_exp(0, A_ECAP, 32'd0, "rst_ecap");
    rd_exp(0, A_MASK, 32'd0, "rst_mask");

    // Clean rise with exact latency
    wr(0, A_MASK, 32'd1);
    rd_exp(0, A_MASK, 32'd1, "mask_rd");
    gpx[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 5) chk("filt_t5", {31'd0, filt[0]}, 32'd0);
      if (t == 6) chk("filt_t6", {31'd0, filt[0]}, 32'd1);
      if (t == 7) chk("irq_t7", {31'd0, irq[0]}, 32'd0);
      if (t == 8) chk("irq_t8", {31'd0, irq[0]}, 32'd1);
    end
    rd_exp(0, A_DATA, 32'd1, "data_hi");
    rd_exp(0, A_ECAP, 32'd1, "ecap_set");
    rd_exp(0, A_EVC, 32'd1, "evcnt_1");

    // Interrupt path and EDGECAP write semantics
    wr(0, A_ECAP, 32'd0);
    chk("irq_after_w0", {31'd0, irq[0]}, 32'd1);
    rd_exp(0, A_ECAP, 32'd1, "ecap_w0_keep");
    wr(0, A_ECAP, 32'd1);
    chk("irq_after_clr", {31'd0, irq[0]}, 32'd0);
    rd_exp(0, A_ECAP, 32'd0, "ecap_cleared");

    // Falling edge is not an event in rise mode
    gpx[0] = 1'b0;
    ticks(10);
    rd_exp(0, A_DATA, 32'd0, "data_lo");
    rd_exp(0, A_EVC, 32'd1, "evcnt_nofall");
    rd_exp(0, A_ECAP, 32'd0, "ecap_nofall");

    // Glitch shorter than FILTER_LEN
    gpx[0] = 1'b1;
    ticks(3);
    gpx[0] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (filt[0]) seen = 1'b1;
    end
    chk("glitch_filt", {31'd0, seen}, 32'd0);
    rd_exp(0, A_ECAP, 32'd0, "glitch_ecap");
    rd_exp(0, A_EVC, 32'd1, "glitch_evcnt");

    // EDGECAP clear landing on the event edge
    gpx[0] = 1'b1;
    ticks(7);
    wr(0, A_ECAP, 32'd1);
    chk("simul_irq", {31'd0, irq[0]}, 32'd1);
    rd_exp(0, A_ECAP, 32'd1, "simul_ecap");
    rd_exp(0, A_EVC, 32'd2, "simul_evcnt2");

    // EVCNT write landing on the event edge
    wr(0, A_ECAP, 32'd1);
    gpx[0] = 1'b0;
    ticks(10);
    gpx[0] = 1'b1;
    ticks(7);
    wr(0, A_EVC, 32'h0000_1234);
    rd_exp(0, A_EVC, 32'd1, "simul_evcnt1");
    rd_exp(0, A_ECAP, 32'd1, "simul_ecap2");
    wr(0, A_EVC, 32'hFFFF_FFFF);
    rd_exp(0, A_EVC, 32'd0, "evcnt_clr");
    wr(0, A_DATA, 32'd0);
    rd_exp(0, A_DATA, 32'd1, "data_ro");

    // Both edges, 4-bit counter wraps
    for (int n = 0; n < 16; n++) begin
      gpx[1] = ~gpx[1];
      ticks(10);
    end
    rd_exp(1, A_EVC, 32'd0, "wrap16");
    gpx[1] = ~gpx[1];
    ticks(10);
    rd_exp(1, A_EVC, 32'd1, "wrap17");

    // Falling-only mode
    gpx[2] = 1'b1;
    ticks(10);
    rd_exp(2, A_EVC, 32'd0, "fall_rise_ign");
    rd_exp(2, A_ECAP, 32'd0, "fall_ecap0");
    gpx[2] = 1'b0;
    ticks(10);
    rd_exp(2, A_EVC, 32'd1, "fall_cnt1");
    rd_exp(2, A_ECAP, 32'd1, "fall_ecap1");
    gpx[2] = 1'b1;
    ticks(10);
    rd_exp(2, A_EVC, 32'd1, "fall_rise_ign2");
    gpx[2] = 1'b0;
    ticks(10);
    rd_exp(2, A_EVC, 32'd2, "fall_cnt2");

    // IDLE_LEVEL=1: idle pin reports nothing
    rd_exp(3, A_EVC, 32'd0, "idle1_evcnt");
    rd_exp(3, A_ECAP, 32'd0, "idle1_ecap");
    rd_exp(3, A_DATA, 32'd1, "idle1_data");
    wr(3, A_MASK, 32'd1);

    // Reset in the middle of a filter count
    gpx[3] = 1'b0;
    ticks(4);
    chk("mid_filt", {31'd0, filt[3]}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_filt3", {31'd0, filt[3]}, 32'd1);
    chk("arst_rd3", rd[3], 32'd0);
    chk("arst_irq0", {31'd0, irq[0]}, 32'd0);
    chk("arst_filt0", {31'd0, filt[0]}, 32'd0);
    gpx[3] = 1'b1;
    ticks(3);
    reset_n = 1'b1;
    ticks(10);
    chk("post_rst_filt", {31'd0, filt[3]}, 32'd1);
    chk("post_rst_irq", {31'd0, irq[3]}, 32'd0);
    rd_exp(3, A_ECAP, 32'd0, "post_rst_ecap");
    rd_exp(3, A_EVC, 32'd0, "post_rst_evcnt");
    rd_exp(3, A_MASK, 32'd0, "post_rst_mask");

    // Filter restarts from scratch after a reset taken mid-count
    gpx[3] = 1'b0;
    ticks(3);
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) chk("restart_t5", {31'd0, filt[3]}, 32'd1);
      if (t == 6) chk("restart_t6", {31'd0, filt[3]}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
